// File: rtl/gpu_pkg.sv
// Shared widths and types for the GPU pixel read path.
package gpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int PIXEL_W = 16;
  localparam int TAG_W   = 32;
  localparam int WORD_W  = 32;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // What must be remembered about a read until its pixel leaves.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             hi_half;
  } side_t;

  // Select the 16-bit pixel out of a 32-bit memory word.
  function automatic pixel_t pick_half(input logic [WORD_W-1:0] word, input logic hi_half);
    return hi_half ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/gpu_pixel_reader_if.sv
// Request, memory and pixel-stream signals of the pixel reader.
// slave is the reader's view; master is the surrounding system's view.
interface gpu_pixel_reader_if;
  import gpu_pkg::*;

  logic              re_valid;
  logic              re_ready;
  logic [ADDR_W-1:0] re_memory_address;
  logic [TAG_W-1:0]  re_tag;

  logic              mem_req;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  logic              se_valid;
  logic              se_ready;
  pixel_t            se_pixel;
  logic [TAG_W-1:0]  se_tag;

  modport slave (
    input  re_valid, re_memory_address, re_tag, mem_ready, mem_rvalid, mem_rdata, se_ready,
    output re_ready, mem_req, mem_address, se_valid, se_pixel, se_tag
  );

  modport master (
    output re_valid, re_memory_address, re_tag, mem_ready, mem_rvalid, mem_rdata, se_ready,
    input  re_ready, mem_req, mem_address, se_valid, se_pixel, se_tag
  );

endinterface

// File: rtl/gpu_sync_fifo.sv
// Small synchronous FIFO; the head entry is readable combinationally so a
// consumer sees it in the same cycle empty drops.
module gpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpu_pixel_reader.sv
// Turns pixel read requests into word reads and returns the selected 16-bit
// half with its tag, in request order, under a credit limit of READ_DEPTH.
module gpu_pixel_reader
  import gpu_pkg::*;
#(
  parameter int READ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  gpu_pixel_reader_if.slave   bus,
  output logic                busy,
  output logic                err_unexpected
);

  localparam int CNT_W = $clog2(READ_DEPTH + 1);

  logic [CNT_W-1:0]  credit_reg, credit_next;
  logic [CNT_W-1:0]  inflight_reg, inflight_next;
  logic              err_unexpected_reg;
  logic              has_credit, issue, rsp_accept, rsp_stray, se_fire;
  side_t             side_in, side_out;
  logic              side_empty, data_empty;
  logic [WORD_W-1:0] word_out;
  logic              unused_addr_bit0;

  // A credit covers a read from issue until its pixel is taken downstream,
  // so the FIFOs below can never overflow.
  assign has_credit   = credit_reg < CNT_W'(READ_DEPTH);
  assign bus.re_ready = rst && has_credit && bus.mem_ready;
  assign bus.mem_req  = rst && bus.re_valid && has_credit;
  assign bus.mem_address = {bus.re_memory_address[ADDR_W-1:2], 2'b00};
  assign unused_addr_bit0 = bus.re_memory_address[0];

  assign issue      = bus.mem_req && bus.mem_ready;
  assign rsp_accept = bus.mem_rvalid && (inflight_reg != '0);
  assign rsp_stray  = bus.mem_rvalid && (inflight_reg == '0);
  assign se_fire    = bus.se_valid && bus.se_ready;

  assign side_in.tag     = bus.re_tag;
  assign side_in.hi_half = bus.re_memory_address[1];

  // Side entries always outnumber or equal data entries, so data_empty alone
  // decides whether a complete pixel is available.
  assign bus.se_valid = !data_empty;
  assign bus.se_pixel = pick_half(word_out, side_out.hi_half);
  assign bus.se_tag   = side_out.tag;

  assign busy           = (credit_reg != '0);
  assign err_unexpected = err_unexpected_reg;

  gpu_sync_fifo #(.WIDTH($bits(side_t)), .DEPTH(READ_DEPTH)) u_side_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (side_in),
    .pop   (se_fire),
    .dout  (side_out),
    .empty (side_empty)
  );

  gpu_sync_fifo #(.WIDTH(WORD_W), .DEPTH(READ_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_accept),
    .din   (bus.mem_rdata),
    .pop   (se_fire),
    .dout  (word_out),
    .empty (data_empty)
  );

  logic unused_side_empty;
  assign unused_side_empty = side_empty;

  // Next-count arithmetic; a simultaneous increment and decrement cancel.
  always_comb begin
    credit_next   = credit_reg;
    inflight_next = inflight_reg;
    if (issue && !se_fire)      credit_next = credit_reg + CNT_W'(1);
    else if (!issue && se_fire) credit_next = credit_reg - CNT_W'(1);
    if (issue && !rsp_accept)      inflight_next = inflight_reg + CNT_W'(1);
    else if (!issue && rsp_accept) inflight_next = inflight_reg - CNT_W'(1);
  end

  // Counter state and the sticky stray-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_reg         <= '0;
      inflight_reg       <= '0;
      err_unexpected_reg <= 1'b0;
    end else begin
      credit_reg   <= credit_next;
      inflight_reg <= inflight_next;
      if (rsp_stray) err_unexpected_reg <= 1'b1;
    end
  end

endmodule
